// File: rtl/keypad_credential_capture.sv
// keypad_credential_capture: collects USER/PASSWORD keypad digits and presents them to the
// gate FSM with a valid/ack/reject handshake, an inactivity timeout and a reject lockout.
module keypad_credential_capture #(
  parameter int W_PASS         = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCK_CYCLES    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              car_present,
  input  logic              key_strobe,
  input  logic [3:0]        key_code,
  input  logic              key_enter,
  input  logic              key_clear,
  input  logic              cred_ack,
  input  logic              cred_reject,
  output logic [W_PASS-1:0] USER,
  output logic [W_PASS-1:0] PASSWORD,
  output logic              cred_valid,
  output logic              locked,
  output logic [2:0]        entry_state
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_USER = 3'd1,
    S_GET_PASS = 3'd2,
    S_PRESENT  = 3'd3,
    S_DONE     = 3'd4,
    S_LOCKED   = 3'd5
  } state_t;
  state_t            r_state;
  logic [W_PASS-1:0] r_user;
  logic [W_PASS-1:0] r_pass;
  logic              r_seen;
  logic              r_cred_valid;
  logic              r_locked;
  logic [TW-1:0]     r_timer;
  logic [LW-1:0]     r_lock_cnt;
  logic [AW-1:0]     r_att;
  logic              w_keying;
  logic              w_any_key;
  logic              w_to_idle;
  logic              w_in_user;
  logic              w_commit;
  logic [W_PASS-1:0] w_field;
  logic [W_PASS-1:0] w_shift;
  logic [AW-1:0]     w_att_nxt;
  always_comb begin
    w_in_user = r_state == S_GET_USER;
    w_keying  = w_in_user || r_state == S_GET_PASS;
    w_any_key = key_strobe || key_enter || key_clear;
    w_field   = w_in_user ? r_user : r_pass;
    w_shift   = (w_field << 4) | W_PASS'(key_code);
    w_commit  = key_enter && (key_strobe || r_seen);
    w_att_nxt = r_att + AW'(1);
    // Car departure outranks keys and responses; timeout only fires on a keyless cycle.
    w_to_idle = (!car_present && (w_keying || r_state == S_PRESENT || r_state == S_DONE)) ||
                (w_keying && !w_any_key && r_timer == TW'(TIMEOUT_CYCLES - 1)) ||
                (r_state == S_LOCKED && r_lock_cnt == LW'(LOCK_CYCLES - 1));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_user       <= '0;
      r_pass       <= '0;
      r_seen       <= 1'b0;
      r_cred_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timer      <= '0;
      r_lock_cnt   <= '0;
      r_att        <= '0;
    end else if (w_to_idle) begin
      r_state      <= S_IDLE;
      r_user       <= '0;
      r_pass       <= '0;
      r_seen       <= 1'b0;
      r_cred_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timer      <= '0;
      r_att        <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (car_present) begin
          r_state <= S_GET_USER;
          r_user  <= '0;
          r_pass  <= '0;
          r_seen  <= 1'b0;
          r_timer <= '0;
        end
        S_GET_USER, S_GET_PASS: begin
          r_timer <= w_any_key ? '0 : r_timer + TW'(1);
          if (key_clear) begin
            r_seen <= 1'b0;
            if (w_in_user) r_user <= '0;
            else r_pass <= '0;
          end else begin
            if (key_strobe) begin
              r_seen <= 1'b1;
              if (w_in_user) r_user <= w_shift;
              else r_pass <= w_shift;
            end
            // The fresh field starts empty, so the later assignment wins over the strobe.
            if (w_commit) begin
              r_seen       <= 1'b0;
              r_state      <= w_in_user ? S_GET_PASS : S_PRESENT;
              r_cred_valid <= !w_in_user;
            end
          end
        end
        S_PRESENT: if (cred_reject) begin
          r_att        <= w_att_nxt;
          r_cred_valid <= 1'b0;
          if (w_att_nxt == AW'(MAX_ATTEMPTS)) begin
            r_state    <= S_LOCKED;
            r_locked   <= 1'b1;
            r_lock_cnt <= '0;
          end else begin
            r_state <= S_GET_PASS;
            r_pass  <= '0;
            r_seen  <= 1'b0;
            r_timer <= '0;
          end
        end else if (cred_ack) begin
          r_state      <= S_DONE;
          r_att        <= '0;
          r_cred_valid <= 1'b0;
        end
        S_DONE: ;
        S_LOCKED: r_lock_cnt <= r_lock_cnt + LW'(1);
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign USER        = r_user;
  assign PASSWORD    = r_pass;
  assign cred_valid  = r_cred_valid;
  assign locked      = r_locked;
  assign entry_state = r_state;
endmodule

// File: tb/tb_keypad_credential_capture.sv
// tb_keypad_credential_capture: scoreboard bench; expected credentials are queued as keys are
// driven and compared when cred_valid rises, with direct state checks around each scenario.
module tb_keypad_credential_capture;
  logic       clk = 1'b0;
  logic       rst;
  logic       car_present;
  logic       key_strobe;
  logic [3:0] key_code;
  logic       key_enter;
  logic       key_clear;
  logic       cred_ack;
  logic       cred_reject;
  logic [3:0] USER;
  logic [3:0] PASSWORD;
  logic       cred_valid;
  logic       locked;
  logic [2:0] entry_state;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_pushed = 0;
  int         n_presented = 0;
  logic [7:0] sb_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] held = '0;
  always #5 clk = ~clk;
  keypad_credential_capture dut (
    .clk(clk), .rst(rst), .car_present(car_present), .key_strobe(key_strobe),
    .key_code(key_code), .key_enter(key_enter), .key_clear(key_clear),
    .cred_ack(cred_ack), .cred_reject(cred_reject), .USER(USER), .PASSWORD(PASSWORD),
    .cred_valid(cred_valid), .locked(locked), .entry_state(entry_state)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (cred_valid && !prev_valid) begin
      n_presented++;
      check("sb_pending", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) check("cred", {USER, PASSWORD}, sb_q.pop_front());
      held <= {USER, PASSWORD};
    end else if (cred_valid && prev_valid) begin
      check("cred_stable", {USER, PASSWORD}, held);
    end
    prev_valid <= cred_valid;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input logic s, input logic [3:0] c, input logic e, input logic cl,
                       input logic a, input logic r);
    key_strobe = s; key_code = c; key_enter = e; key_clear = cl; cred_ack = a; cred_reject = r;
    @(negedge clk);
    key_strobe = 0; key_enter = 0; key_clear = 0; cred_ack = 0; cred_reject = 0;
  endtask
  task automatic digit_enter(input logic [3:0] c);
    drive(1, c, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
  endtask
  task automatic expect_cred(input logic [3:0] u, input logic [3:0] p);
    sb_q.push_back({u, p});
    n_pushed++;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 0; car_present = 0; key_strobe = 0; key_code = 0; key_enter = 0; key_clear = 0;
    cred_ack = 0; cred_reject = 0;
    tick(2);
    check("rst_state", entry_state, 0);
    check("rst_fields", {USER, PASSWORD}, 0);
    check("rst_flags", {cred_valid, locked}, 0);
    rst = 1;
    tick(1);
    check("idle_no_car", entry_state, 0);
    // normal entry
    car_present = 1;
    tick(1);
    check("n_get_user", entry_state, 1);
    expect_cred(3, 5);
    digit_enter(3);
    check("n_get_pass", entry_state, 2);
    check("n_user", USER, 3);
    digit_enter(5);
    check("n_present", {entry_state, cred_valid}, {3'd3, 1'b1});
    drive(0, 0, 0, 0, 1, 0);
    check("n_done", {entry_state, cred_valid}, {3'd4, 1'b0});
    car_present = 0;
    tick(1);
    check("n_idle", {entry_state, USER, PASSWORD}, 0);
    // retry
    car_present = 1;
    tick(1);
    digit_enter(3);
    expect_cred(3, 2);
    digit_enter(2);
    drive(0, 0, 0, 0, 0, 1);
    check("r_back1", {entry_state, USER, PASSWORD, cred_valid}, {3'd2, 4'd3, 4'd0, 1'b0});
    expect_cred(3, 3);
    digit_enter(3);
    drive(0, 0, 0, 0, 0, 1);
    check("r_back2", {entry_state, USER, PASSWORD}, {3'd2, 4'd3, 4'd0});
    expect_cred(3, 5);
    digit_enter(5);
    drive(0, 0, 0, 0, 1, 0);
    check("r_done", entry_state, 4);
    car_present = 0;
    tick(1);
    // lockout
    car_present = 1;
    tick(1);
    digit_enter(1);
    for (int k = 0; k < 3; k++) begin
      expect_cred(1, 9);
      digit_enter(9);
      drive(0, 0, 0, 0, 0, 1);
    end
    check("l_enter", {entry_state, locked, cred_valid}, {3'd5, 1'b1, 1'b0});
    for (int i = 1; i < 32; i++) begin
      car_present = i[1];
      drive(1, i[3:0], i[0], i[2], i[0], !i[0]);
      check("l_hold", {entry_state, locked, cred_valid}, {3'd5, 1'b1, 1'b0});
    end
    car_present = 0;
    tick(1);
    check("l_release", {entry_state, locked, USER, PASSWORD}, 0);
    // timeout
    car_present = 1;
    tick(1);
    check("t_user", entry_state, 1);
    tick(15);
    check("t_before", entry_state, 1);
    tick(1);
    check("t_expire", {entry_state, USER, PASSWORD}, 0);
    tick(1);
    check("t_reenter", entry_state, 1);
    tick(14);
    drive(1, 6, 0, 0, 0, 0);
    tick(15);
    check("t_restart", {entry_state, USER}, {3'd1, 4'd6});
    tick(1);
    check("t_expire2", {entry_state, USER}, 0);
    car_present = 0;
    tick(1);
    // priority
    car_present = 1;
    tick(1);
    drive(1, 4, 0, 0, 0, 0);
    check("p_user4", USER, 4);
    drive(1, 7, 0, 1, 0, 0);
    check("p_clear", {entry_state, USER}, {3'd1, 4'd0});
    drive(0, 0, 1, 0, 0, 0);
    check("p_empty_enter", entry_state, 1);
    digit_enter(3);
    drive(1, 9, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    check("p_clear_pass", {entry_state, PASSWORD}, {3'd2, 4'd0});
    expect_cred(3, 5);
    drive(1, 5, 1, 0, 0, 0);
    check("p_strobe_enter", {entry_state, PASSWORD}, {3'd3, 4'd5});
    drive(0, 0, 0, 0, 1, 1);
    check("p_ack_rej", {entry_state, USER, PASSWORD}, {3'd2, 4'd3, 4'd0});
    expect_cred(3, 6);
    digit_enter(6);
    drive(0, 0, 0, 0, 1, 0);
    check("p_done", entry_state, 4);
    car_present = 0;
    tick(1);
    // reset mid-PRESENT
    car_present = 1;
    tick(1);
    digit_enter(3);
    expect_cred(3, 8);
    digit_enter(8);
    check("x_present", entry_state, 3);
    #2;
    rst = 0;
    #1;
    check("x_async", {entry_state, USER, PASSWORD, cred_valid, locked}, 0);
    rst = 1;
    @(negedge clk);
    tick(1);
    check("x_resume", entry_state, 1);
    digit_enter(2);
    expect_cred(2, 4);
    digit_enter(4);
    check("x_present2", {entry_state, cred_valid}, {3'd3, 1'b1});
    car_present = 0;
    drive(0, 0, 0, 0, 1, 0);
    check("x_car_gone", {entry_state, cred_valid}, 0);
    tick(1);
    check("sb_empty", sb_q.size(), 0);
    check("n_presented", n_presented, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
